// File: rtl/time_counter.sv
// 24-hour BCD HH:MM timekeeper: counts one_second pulses, supports validated time loads.
// Latency: one cycle from a sampled pulse/load to the outputs. Backpressure: none, and load beats tick.
module time_counter #(
  parameter int SEC_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       one_second,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       minute_tick,
  output logic       load_err
);

  localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);

  logic [5:0] sec_cnt;
  logic       load_legal;
  logic [3:0] nxt_ms_hr, nxt_ls_hr, nxt_ms_min, nxt_ls_min;

  assign load_legal = (new_current_time_ms_hr  <= 4'd2) &&
                      (new_current_time_ls_hr  <= 4'd9) &&
                      (new_current_time_ms_min <= 4'd5) &&
                      (new_current_time_ls_min <= 4'd9) &&
                      !((new_current_time_ms_hr == 4'd2) && (new_current_time_ls_hr > 4'd3));

  // One-minute BCD cascade; the hour carry only fires when both minute digits roll over.
  always_comb begin
    nxt_ms_hr  = current_time_ms_hr;
    nxt_ls_hr  = current_time_ls_hr;
    nxt_ms_min = current_time_ms_min;
    nxt_ls_min = current_time_ls_min + 4'd1;
    if (current_time_ls_min == 4'd9) begin
      nxt_ls_min = 4'd0;
      nxt_ms_min = current_time_ms_min + 4'd1;
      if (current_time_ms_min == 4'd5) begin
        nxt_ms_min = 4'd0;
        if ((current_time_ms_hr == 4'd2) && (current_time_ls_hr == 4'd3)) begin
          nxt_ms_hr = 4'd0;
          nxt_ls_hr = 4'd0;
        end else if (current_time_ls_hr == 4'd9) begin
          nxt_ls_hr = 4'd0;
          nxt_ms_hr = current_time_ms_hr + 4'd1;
        end else begin
          nxt_ls_hr = current_time_ls_hr + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt             <= 6'd0;
      current_time_ms_hr  <= 4'd0;
      current_time_ls_hr  <= 4'd0;
      current_time_ms_min <= 4'd0;
      current_time_ls_min <= 4'd0;
      minute_tick         <= 1'b0;
      load_err            <= 1'b0;
    end else begin
      minute_tick <= 1'b0;
      load_err    <= 1'b0;
      // A load swallows any coincident second pulse, even when the load is rejected.
      if (load_new_c) begin
        if (load_legal) begin
          current_time_ms_hr  <= new_current_time_ms_hr;
          current_time_ls_hr  <= new_current_time_ls_hr;
          current_time_ms_min <= new_current_time_ms_min;
          current_time_ls_min <= new_current_time_ls_min;
          sec_cnt             <= 6'd0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (one_second) begin
        if (sec_cnt == SEC_LAST) begin
          sec_cnt             <= 6'd0;
          current_time_ms_hr  <= nxt_ms_hr;
          current_time_ls_hr  <= nxt_ls_hr;
          current_time_ms_min <= nxt_ms_min;
          current_time_ls_min <= nxt_ls_min;
          minute_tick         <= 1'b1;
        end else begin
          sec_cnt <= sec_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with a minutes-of-day reference model checked every cycle.
module tb_time_counter;

  localparam int SPM = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        one_second = 1'b0;
  logic        load_new_c = 1'b0;
  logic [15:0] new_val = 16'h0;
  logic [3:0]  ms_hr, ls_hr, ms_min, ls_min;
  logic        minute_tick, load_err;
  logic [15:0] digits;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: time as minutes since midnight plus a seconds count.
  int m_min = 0;
  int m_sec = 0;
  bit m_tick = 1'b0;
  bit m_err = 1'b0;

  time_counter #(.SEC_PER_MIN(SPM)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .one_second(one_second),
    .load_new_c(load_new_c),
    .new_current_time_ms_hr(new_val[15:12]),
    .new_current_time_ls_hr(new_val[11:8]),
    .new_current_time_ms_min(new_val[7:4]),
    .new_current_time_ls_min(new_val[3:0]),
    .current_time_ms_hr(ms_hr),
    .current_time_ls_hr(ls_hr),
    .current_time_ms_min(ms_min),
    .current_time_ls_min(ls_min),
    .minute_tick(minute_tick),
    .load_err(load_err)
  );

  assign digits = {ms_hr, ls_hr, ms_min, ls_min};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit legal_time(input logic [15:0] v);
    int hours;
    hours = int'(v[15:12]) * 10 + int'(v[11:8]);
    return (v[11:8] <= 9) && (v[3:0] <= 9) && (v[7:4] <= 5) && (hours < 24);
  endfunction

  function automatic logic [15:0] to_bcd(input int minutes);
    int h, m;
    h = minutes / 60;
    m = minutes % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_tick = 0; m_err = 0;
    end else begin
      m_tick = 0;
      m_err = 0;
      if (load_new_c) begin
        if (legal_time(new_val)) begin
          m_min = (int'(new_val[15:12]) * 10 + int'(new_val[11:8])) * 60 +
                  int'(new_val[7:4]) * 10 + int'(new_val[3:0]);
          m_sec = 0;
        end else begin
          m_err = 1;
        end
      end else if (one_second) begin
        m_sec = m_sec + 1;
        if (m_sec == SPM) begin
          m_sec = 0;
          m_min = (m_min + 1) % 1440;
          m_tick = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_outputs", {14'd0, digits, minute_tick, load_err}, {14'd0, to_bcd(m_min), m_tick, m_err});
  end

  // Apply inputs for one cycle; returns on the following negedge with inputs idle.
  task automatic drive(input bit os, input bit ld, input logic [15:0] v);
    one_second = os;
    load_new_c = ld;
    new_val = v;
    @(negedge clk);
    one_second = 1'b0;
    load_new_c = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] bad_vals [4];
    bad_vals[0] = 16'h2400;
    bad_vals[1] = 16'h1960;
    bad_vals[2] = 16'h070A;
    bad_vals[3] = 16'h3000;

    #1 rst_n = 1'b0;
    @(negedge clk);
    pulses(3);
    check("reset_digits", digits, 16'h0000);
    check("reset_tick", minute_tick, 1'b0);
    check("reset_err", load_err, 1'b0);
    rst_n = 1'b1;

    pulses(SPM);
    check("first_minute", digits, 16'h0001);
    check("first_tick", minute_tick, 1'b1);
    drive(1'b0, 1'b0, 16'h0);
    check("tick_one_cycle", minute_tick, 1'b0);

    drive(1'b0, 1'b1, 16'h1234);
    check("load_1234", digits, 16'h1234);
    check("load_1234_err", load_err, 1'b0);
    check("load_1234_tick", minute_tick, 1'b0);
    pulses(SPM - 1);
    check("hold_1234", digits, 16'h1234);
    pulses(1);
    check("adv_1235", digits, 16'h1235);

    drive(1'b0, 1'b1, 16'h0959);
    pulses(SPM);
    check("carry_1000", digits, 16'h1000);

    drive(1'b0, 1'b1, 16'h2359);
    pulses(SPM);
    check("wrap_0000", digits, 16'h0000);
    check("wrap_tick", minute_tick, 1'b1);
    drive(1'b0, 1'b0, 16'h0);
    check("wrap_tick_clear", minute_tick, 1'b0);

    drive(1'b0, 1'b1, 16'h0707);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, bad_vals[i]);
      check("illegal_hold", digits, 16'h0707);
      check("illegal_err", load_err, 1'b1);
      drive(1'b0, 1'b0, 16'h0);
      check("illegal_err_clear", load_err, 1'b0);
    end

    pulses(SPM - 1);
    drive(1'b1, 1'b1, 16'h0500);
    check("collide_0500", digits, 16'h0500);
    check("collide_tick", minute_tick, 1'b0);
    pulses(SPM - 1);
    check("collide_sec_clear", digits, 16'h0500);
    pulses(1);
    check("collide_0501", digits, 16'h0501);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 16'h0812);
      check("held_load", digits, 16'h0812);
    end
    pulses(SPM);
    check("held_load_adv", digits, 16'h0813);

    drive(1'b0, 1'b1, 16'h1542);
    pulses(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", digits, 16'h0000);
    check("async_reset_tick", minute_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses(SPM);
    check("post_reset_minute", digits, 16'h0001);
    drive(1'b0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
